biquad8_coeff_loader: RTL and testbench
=======================================

# biquad8_coeff_loader

Coefficient sequencer that feeds the serial coefficient port of the 8-sample biquad incremental (IIR recursion) stage. The host writes coefficient words into a shadow bank at random. On an update request the block snapshots the bank and emits a serial burst: per-word write strobes, data skewed one cycle behind each strobe (the consumer registers its strobes once), then a single update strobe. All DSP columns of the incremental stage are fed in parallel, so one burst reprograms the whole stage.

## Interface
Parameters:
- `NCOEFF`, 2: coefficients per burst (≥1); the incremental stage uses 2 (word 0 = a, word 1 = b).
- `CBITS`, 18: coefficient width (DSP B port).
- `ABITS`, `$clog2(NCOEFF)` (min 1): host address width.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_i` in 1: host write strobe.
- `wr_addr_i` in ABITS: shadow index; writes with index ≥ NCOEFF are ignored.
- `wr_dat_i` in CBITS: coefficient word.
- `update_req_i` in 1: single-cycle request to run a burst.
- `busy_o` out 1: burst in progress.
- `done_o` out 1: one-cycle pulse at burst end.
- `coeff_wr_o` out 1: to consumer `coeff_wr_i`.
- `coeff_dat_o` out CBITS: to consumer `coeff_dat_i`.
- `coeff_update_o` out 1: to consumer `coeff_update_i`.

## Operation
- Shadow bank: NCOEFF × CBITS registers, reset to 0. Host writes are accepted in every state.
- Snapshot: a working copy taken when a burst starts. A host write in the same cycle as the snapshot is forwarded into the snapshot. Later writes affect only the shadow bank.
- FSM states: IDLE, LOAD, UPDATE.
  - IDLE: on `update_req_i`, take the snapshot, set k=0, and go to LOAD.
  - LOAD: assert `coeff_wr_o` for word k. Increment k. After word NCOEFF-1, go to UPDATE.
  - UPDATE: one cycle with `coeff_update_o`=1 and `done_o`=1. If a request is pending, take a fresh snapshot, clear the pending flag, and go to LOAD. Otherwise go to IDLE.
- Data skew: `coeff_dat_o` carries word k in the cycle after the `coeff_wr_o` for word k. In all other cycles it is 0.
- Request while busy (LOAD/UPDATE): sets a one-deep pending flag. Further requests merge into it. A request in the UPDATE cycle also counts as pending.
- Emission order is index order. Word 0 ends in the deepest cascade register. Software writes a at index 0 and b at index 1.
- Reset mid-burst: the burst is aborted and the FSM goes to IDLE. The pending flag and shadow bank are cleared. All outputs are 0 on the next cycle. The consumer's shadow (B1) is left partially loaded but not applied, because no update strobe was issued.

## Timing
- Every output is registered. Reset value of every output: 0.
- Request sampled at cycle c0:
  - `coeff_wr_o`=1 in cycles c1..cNCOEFF.
  - `coeff_dat_o`=word k in cycle c(k+2).
  - Cycle c(NCOEFF+1): `coeff_dat_o`=word NCOEFF-1, `coeff_update_o`=1, `done_o`=1.
  - `busy_o`=1 in cycles c1..c(NCOEFF+1).
- Burst length: NCOEFF+1 cycles. Back-to-back bursts (pending request) have no idle gap: the next `coeff_wr_o` arrives in the cycle after UPDATE.
- Consumer-side applied latency: the consumer's B2 load takes effect 2 cycles after `coeff_update_o`.

## Configuration
- `BIQUAD8_COEFF_AUTO_UPDATE_EN` defined: a host write to index NCOEFF-1 also acts as `update_req_i` in the same cycle. Forwarding puts that word into the snapshot, and busy/pending rules still apply.
- Undefined: bursts start only on `update_req_i`.

## Structure
- Shared package `biquad8_pkg`: coefficient width constant (18), FSM state enum (IDLE/LOAD/UPDATE), and default NCOEFF for the incremental stage.
- Single flat module. The shadow bank, snapshot and FSM are inline; no sub-module is warranted.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs → all outputs 0 and the shadow bank reads back 0 through a subsequent burst (`coeff_dat_o`=0,0).
- Basic burst, NCOEFF=2: write idx0=0x01000 and idx1=0x3F000, then request at c0 → `coeff_wr_o` in c1,c2; `coeff_dat_o`=0x01000@c2 and 0x3F000@c3; `coeff_update_o`/`done_o`@c3; `busy_o` in c1–c3.
- Write and request in the same cycle: write idx1=0x00ABC with `update_req_i` at c0 → 0x00ABC appears @c3.
- Request during busy at c2, with idx0 rewritten to 0x12345 at c2 → the second burst starts at c4 with 0x12345@c5; `busy_o` stays high c1–c6; two `done_o` pulses (c3, c6).
- Reset asserted at c2 of a burst → no `coeff_update_o`, outputs 0 from c3; a later request replays zeros.
- With `BIQUAD8_COEFF_AUTO_UPDATE_EN`: write idx1 at c0 with no request → burst identical to the basic-burst case. Without the macro → no activity.

Source files
------------

// File: rtl/biquad8_pkg.sv
// biquad8_pkg: shared constants and the coefficient-sequencer state type for the
// biquad8 incremental stage.
package biquad8_pkg;

    localparam int BIQUAD8_CBITS  = 18;
    localparam int BIQUAD8_NCOEFF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UPDATE = 2'd2
    } coeff_state_t;

endpackage

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader: host shadow bank, burst snapshot and serial coefficient sequencer.
// Option: define BIQUAD8_COEFF_AUTO_UPDATE_EN so a write to the last index also requests a burst.
module biquad8_coeff_loader
    import biquad8_pkg::*;
#(
    parameter int NCOEFF = BIQUAD8_NCOEFF,
    parameter int CBITS  = BIQUAD8_CBITS,
    parameter int ABITS  = (NCOEFF > 1) ? $clog2(NCOEFF) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [ABITS-1:0] wr_addr_i,
    input  logic [CBITS-1:0] wr_dat_i,
    input  logic             update_req_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             coeff_wr_o,
    output logic [CBITS-1:0] coeff_dat_o,
    output logic             coeff_update_o
);

    logic [CBITS-1:0] r_bank [NCOEFF];
    logic [CBITS-1:0] r_snap [NCOEFF];
    logic [CBITS-1:0] w_fwd  [NCOEFF];
    coeff_state_t     r_state;
    logic [ABITS-1:0] r_k;
    logic             r_pending;
    logic             w_req;
    logic             r_busy;
    logic             r_done;
    logic             r_wr;
    logic             r_upd;
    logic [CBITS-1:0] r_dat;

    // Snapshot source: a same-cycle host write wins over the stored shadow word.
    always_comb begin
        for (int i = 0; i < NCOEFF; i++) begin
            w_fwd[i] = (wr_i && (wr_addr_i == ABITS'(i))) ? wr_dat_i : r_bank[i];
        end
    end

`ifdef BIQUAD8_COEFF_AUTO_UPDATE_EN
    assign w_req = update_req_i || (wr_i && (wr_addr_i == ABITS'(NCOEFF - 1)));
`else
    assign w_req = update_req_i;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEFF; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCOEFF; i++) begin
                if (wr_i && (wr_addr_i == ABITS'(i))) begin
                    r_bank[i] <= wr_dat_i;
                end
            end
        end
    end

    // Data trails each strobe by one cycle because the consumer registers its strobe once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr      <= 1'b0;
            r_upd     <= 1'b0;
            r_dat     <= '0;
        end else begin
            r_dat  <= '0;
            r_wr   <= 1'b0;
            r_upd  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        for (int i = 0; i < NCOEFF; i++) begin
                            r_snap[i] <= w_fwd[i];
                        end
                        r_k     <= '0;
                        r_state <= LOAD;
                        r_wr    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_req) begin
                        r_pending <= 1'b1;
                    end
                    r_dat <= r_snap[r_k];
                    if (r_k == ABITS'(NCOEFF - 1)) begin
                        r_state <= UPDATE;
                        r_upd   <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_k  <= r_k + 1'b1;
                        r_wr <= 1'b1;
                    end
                end
                UPDATE: begin
                    // A request landing in this cycle chains like an earlier pending one.
                    if (r_pending || w_req) begin
                        for (int i = 0; i < NCOEFF; i++) begin
                            r_snap[i] <= w_fwd[i];
                        end
                        r_k       <= '0;
                        r_pending <= 1'b0;
                        r_state   <= LOAD;
                        r_wr      <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign coeff_wr_o     = r_wr;
    assign coeff_dat_o    = r_dat;
    assign coeff_update_o = r_upd;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// tb_biquad8_coeff_loader: directed and random checks of the coefficient sequencer
// against a burst-schedule reference model.
module tb_biquad8_coeff_loader;

    localparam int NCOEFF = 2;
    localparam int CBITS  = 18;
    localparam int ABITS  = 1;
    localparam int OW     = CBITS + 4;
    localparam int MAXC   = 1024;

    logic             clk;
    logic             rst_n;
    logic             wr_i;
    logic [ABITS-1:0] wr_addr_i;
    logic [CBITS-1:0] wr_dat_i;
    logic             update_req_i;
    logic             busy_o;
    logic             done_o;
    logic             coeff_wr_o;
    logic [CBITS-1:0] coeff_dat_o;
    logic             coeff_update_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected outputs per absolute cycle, filled in whenever the model starts a burst.
    bit             expBusy [MAXC];
    bit             expDone [MAXC];
    bit             expWr   [MAXC];
    bit             expUpd  [MAXC];
    bit [CBITS-1:0] expDat  [MAXC];
    bit [CBITS-1:0] shadow  [NCOEFF];
    bit             pending  = 1'b0;
    int             burstEnd = -1;

    biquad8_coeff_loader #(.NCOEFF(NCOEFF), .CBITS(CBITS), .ABITS(ABITS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_i(wr_i),
        .wr_addr_i(wr_addr_i),
        .wr_dat_i(wr_dat_i),
        .update_req_i(update_req_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .coeff_wr_o(coeff_wr_o),
        .coeff_dat_o(coeff_dat_o),
        .coeff_update_o(coeff_update_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [OW-1:0] obsVec();
        return {busy_o, done_o, coeff_wr_o, coeff_update_o, coeff_dat_o};
    endfunction

    function automatic logic [OW-1:0] expVec(input int c);
        return {expBusy[c], expDone[c], expWr[c], expUpd[c], expDat[c]};
    endfunction

    // Reference model: each accepted request schedules a whole burst into the expectation arrays.
    task automatic modelStep();
        bit             req;
        bit             start;
        bit [CBITS-1:0] snap [NCOEFF];
        if (!rst_n) begin
            for (int j = cyc + 1; j < MAXC; j++) begin
                expBusy[j] = 1'b0;
                expDone[j] = 1'b0;
                expWr[j]   = 1'b0;
                expUpd[j]  = 1'b0;
                expDat[j]  = '0;
            end
            for (int i = 0; i < NCOEFF; i++) shadow[i] = '0;
            pending  = 1'b0;
            burstEnd = -1;
            return;
        end
        req = update_req_i;
`ifdef BIQUAD8_COEFF_AUTO_UPDATE_EN
        if (wr_i && int'(wr_addr_i) == NCOEFF - 1) req = 1'b1;
`endif
        start = 1'b0;
        if (cyc < burstEnd) begin
            if (req) pending = 1'b1;
        end else if (cyc == burstEnd) begin
            start = pending || req;
        end else begin
            start = req;
        end
        if (start && cyc + NCOEFF + 2 < MAXC) begin
            for (int i = 0; i < NCOEFF; i++) snap[i] = shadow[i];
            if (wr_i && int'(wr_addr_i) < NCOEFF) snap[wr_addr_i] = wr_dat_i;
            for (int j = 1; j <= NCOEFF; j++) begin
                expWr[cyc + j]       = 1'b1;
                expBusy[cyc + j]     = 1'b1;
                expDat[cyc + j + 1]  = snap[j - 1];
            end
            expBusy[cyc + NCOEFF + 1] = 1'b1;
            expUpd[cyc + NCOEFF + 1]  = 1'b1;
            expDone[cyc + NCOEFF + 1] = 1'b1;
            burstEnd = cyc + NCOEFF + 1;
            pending  = 1'b0;
        end
        if (wr_i && int'(wr_addr_i) < NCOEFF) shadow[wr_addr_i] = wr_dat_i;
    endtask

    // Drives one cycle of inputs, advances the model, and returns #1 after the next edge.
    task automatic applyStimulus(input logic r, input logic w, input logic [ABITS-1:0] a,
                                 input logic [CBITS-1:0] d, input logic q);
        rst_n        = r;
        wr_i         = w;
        wr_addr_i    = a;
        wr_dat_i     = d;
        update_req_i = q;
        modelStep();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'($urandom), ABITS'($urandom), CBITS'($urandom), 1'($urandom));
            checks++;
            if (obsVec() !== '0) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc=%0d got=%h expected=%h", cyc, obsVec(), {OW{1'b0}});
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obsVec() !== expVec(cyc) || coeff_dat_o !== 18'h0) begin
                errors++;
                $display("[TB] FAIL reset_zero_burst cyc=%0d got=%h expected=%h", cyc, obsVec(), expVec(cyc));
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
        end
    endtask

    task automatic test_basic_burst();
        logic [OW-1:0] lit [4];
        lit[0] = {4'b1010, 18'h00000};
        lit[1] = {4'b1010, 18'h01000};
        lit[2] = {4'b1101, 18'h3F000};
        lit[3] = {4'b0000, 18'h00000};
        applyStimulus(1'b1, 1'b1, 1'b0, 18'h01000, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 18'h3F000, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obsVec() !== lit[i]) begin
                errors++;
                $display("[TB] FAIL basic_burst_c%0d got=%h expected=%h", i + 1, obsVec(), lit[i]);
            end
            checks++;
            if (obsVec() !== expVec(cyc)) begin
                errors++;
                $display("[TB] FAIL basic_model cyc=%0d got=%h expected=%h", cyc, obsVec(), expVec(cyc));
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
        end
    endtask

    task automatic test_write_with_request();
        applyStimulus(1'b1, 1'b1, 1'b1, 18'h00ABC, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (obsVec() !== expVec(cyc)) begin
                errors++;
                $display("[TB] FAIL fwd_model cyc=%0d got=%h expected=%h", cyc, obsVec(), expVec(cyc));
            end
            if (c == 3) begin
                checks++;
                if (coeff_dat_o !== 18'h00ABC || coeff_update_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL fwd_word_c3 got dat=%h upd=%b expected dat=00abc upd=1", coeff_dat_o, coeff_update_o);
                end
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int doneCount = 0;
        int busyCount = 0;
        for (int s = 0; s < 8; s++) begin
            if (s == 0)      applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
            else if (s == 2) applyStimulus(1'b1, 1'b1, 1'b0, 18'h12345, 1'b1);
            else             applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
            doneCount += int'(done_o);
            busyCount += int'(busy_o);
            checks++;
            if (obsVec() !== expVec(cyc)) begin
                errors++;
                $display("[TB] FAIL b2b_model cyc=%0d got=%h expected=%h", cyc, obsVec(), expVec(cyc));
            end
            if (s + 1 == 5) begin
                checks++;
                if (coeff_dat_o !== 18'h12345 || coeff_wr_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_second_word0 got dat=%h wr=%b expected dat=12345 wr=1", coeff_dat_o, coeff_wr_o);
                end
            end
        end
        checks++;
        if (doneCount != 2 || busyCount != 6) begin
            errors++;
            $display("[TB] FAIL b2b_counts got done=%0d busy=%0d expected done=2 busy=6", doneCount, busyCount);
        end
    endtask

    task automatic test_reset_mid_burst();
        int updCount = 0;
        for (int s = 0; s < 6; s++) begin
            if (s == 0)      applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
            else if (s == 2) applyStimulus(1'b0, 1'b0, 1'b0, 18'h0, 1'b0);
            else             applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
            updCount += int'(coeff_update_o);
            checks++;
            if (obsVec() !== expVec(cyc) || (s >= 2 && obsVec() !== '0)) begin
                errors++;
                $display("[TB] FAIL abort_c%0d got=%h expected=%h", s + 1, obsVec(), expVec(cyc));
            end
        end
        checks++;
        if (updCount != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_update got=%0d expected=0", updCount);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obsVec() !== expVec(cyc) || coeff_dat_o !== 18'h0) begin
                errors++;
                $display("[TB] FAIL abort_replay cyc=%0d got=%h expected=%h", cyc, obsVec(), expVec(cyc));
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
        end
    endtask

    task automatic test_auto_update();
        logic [OW-1:0] lit [4];
`ifdef BIQUAD8_COEFF_AUTO_UPDATE_EN
        lit[0] = {4'b1010, 18'h00000};
        lit[1] = {4'b1010, 18'h01000};
        lit[2] = {4'b1101, 18'h3F000};
        lit[3] = {4'b0000, 18'h00000};
`else
        for (int i = 0; i < 4; i++) lit[i] = '0;
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 18'h01000, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 18'h3F000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obsVec() !== lit[i] || obsVec() !== expVec(cyc)) begin
                errors++;
                $display("[TB] FAIL auto_update_c%0d got=%h expected=%h", i + 1, obsVec(), lit[i]);
            end
            applyStimulus(1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 63) != 0), 1'($urandom), ABITS'($urandom),
                          CBITS'($urandom), 1'($urandom_range(0, 5) == 0));
            checks++;
            if (obsVec() !== expVec(cyc)) begin
                errors++;
                $display("[TB] FAIL random_model cyc=%0d got=%h expected=%h", cyc, obsVec(), expVec(cyc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_write_with_request();
        test_back_to_back();
        test_reset_mid_burst();
        test_auto_update();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
